// File: rtl/sram_pkg.sv
// sram_pkg: default geometry of sram_256x8 and the clear-sweep state type.
// The state type exists only when SRAM_CLEAR_ON_RESET_EN is defined.
package sram_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
`ifdef SRAM_CLEAR_ON_RESET_EN
  typedef enum logic {CLEAR, READY} state_t;
`endif
endpackage

// File: rtl/sram_array.sv
// sram_array: single-port storage array with a registered, read-first read port.
module sram_array #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [0:2**AW-1];
  logic [DW-1:0] rdata_q;
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end
  assign rdata = rdata_q;
endmodule

// File: rtl/sram_256x8.sv
// sram_256x8: chip-selected synchronous RAM with registered, reset-cleared read data.
// Define SRAM_CLEAR_ON_RESET_EN to add a post-reset zeroing sweep and a busy output.
import sram_pkg::*;

module sram_256x8 #(
  parameter int ADDR_W = sram_pkg::ADDR_W,
  parameter int DATA_W = sram_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              wr,
  input  logic              rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
`ifdef SRAM_CLEAR_ON_RESET_EN
  output logic              busy,
`endif
  output logic [DATA_W-1:0] dout
);
  logic              we, clr, rd_v_d, rd_v_q;
  logic [ADDR_W-1:0] waddr, clr_addr;
  logic [DATA_W-1:0] wdata, rdata, hold_d, hold_q;
`ifdef SRAM_CLEAR_ON_RESET_EN
  state_t            state_d, state_q;
  logic [ADDR_W-1:0] cnt_d, cnt_q;
  logic              busy_q;
  always_comb begin
    state_d = (state_q == CLEAR && &cnt_q) ? READY : state_q;
    cnt_d   = (state_q == CLEAR) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == CLEAR);
    end
  end
  assign busy     = busy_q;
  assign clr      = busy_q;
  assign clr_addr = cnt_q;
`else
  assign clr      = 1'b0;
  assign clr_addr = '0;
`endif
  // dout shows the array's fresh word right after a read, otherwise the last word read.
  always_comb begin
    we     = rst_n & (clr | (cs & wr));
    waddr  = clr ? clr_addr : addr;
    wdata  = clr ? '0 : din;
    rd_v_d = rst_n & ~clr & cs & rd;
    hold_d = rd_v_q ? rdata : hold_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_v_q <= 1'b0;
      hold_q <= '0;
    end else begin
      rd_v_q <= rd_v_d;
      hold_q <= hold_d;
    end
  end
  assign dout = rd_v_q ? rdata : hold_q;
  sram_array #(.AW(ADDR_W), .DW(DATA_W)) u_array (
    .clk  (clk),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata),
    .raddr(addr),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_sram_256x8.sv
// tb_sram_256x8: directed self-checking bench for sram_256x8 (SRAM_CLEAR_ON_RESET_EN aware).
module tb_sram_256x8;
  logic       clk, rst_n, cs, wr, rd;
  logic [7:0] addr, din, dout;
  int         total = 0, bad = 0, n;
`ifdef SRAM_CLEAR_ON_RESET_EN
  logic       busy;
  localparam logic [7:0] RST_KEEP = 8'h00;
`else
  localparam logic [7:0] RST_KEEP = 8'h3C;
`endif

  sram_256x8 dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .wr(wr), .rd(rd),
    .addr(addr), .din(din),
`ifdef SRAM_CLEAR_ON_RESET_EN
    .busy(busy),
`endif
    .dout(dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write(input logic [7:0] a, input logic [7:0] d);
    cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = a; din = d;
    tick;
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic read(input logic [7:0] a);
    cs = 1'b1; wr = 1'b0; rd = 1'b1; addr = a;
    tick;
    cs = 1'b0; rd = 1'b0;
  endtask

  task automatic wait_clear(output int cnt);
    cnt = 0;
`ifdef SRAM_CLEAR_ON_RESET_EN
    while (busy === 1'b1 && cnt < 1000) begin
      tick;
      cnt++;
    end
`endif
  endtask

  initial begin
    logic [7:0] a;
    rst_n = 1'b0; cs = 1'b0; wr = 1'b0; rd = 1'b0; addr = '0; din = '0;
    tick; tick;
    chk("reset_dout", dout, 8'h00);
    rst_n = 1'b1;
`ifdef SRAM_CLEAR_ON_RESET_EN
    chk("busy_after_reset", busy, 1'b1);
    wait_clear(n);
    chk("first_sweep_len", n, 256);
`endif
    write(8'h05, 8'h3C);
    read(8'h05);
    chk("pre_reset_read", dout, 8'h3C);
    rst_n = 1'b0; cs = 1'b1; wr = 1'b1; addr = 8'h05; din = 8'hAA;
    tick;
    chk("reset_cyc1_dout", dout, 8'h00);
    tick;
    chk("reset_cyc2_dout", dout, 8'h00);
    rst_n = 1'b1; cs = 1'b0; wr = 1'b0;
    wait_clear(n);
    read(8'h05);
    chk("reset_write_blocked", dout, RST_KEEP);

    for (int k = 0; k < 256; k++) write(8'(k), 8'(k) ^ 8'h5A);
    for (int i = 0; i < 256; i++) begin
      a = 8'($urandom_range(0, 255));
      read(a);
      chk("readback", dout, a ^ 8'h5A);
    end
    read(8'h00);
    chk("readback_lo", dout, 8'h5A);
    read(8'hFF);
    chk("readback_hi", dout, 8'hA5);

    write(8'h10, 8'h33);
    read(8'h10);
    chk("cs_pre", dout, 8'h33);
    cs = 1'b0; wr = 1'b1; rd = 1'b1; addr = 8'h10; din = 8'hFF;
    tick;
    chk("cs_low_hold", dout, 8'h33);
    addr = 8'h11;
    tick;
    chk("cs_low_hold2", dout, 8'h33);
    wr = 1'b0; rd = 1'b0;
    read(8'h10);
    chk("cs_low_no_write", dout, 8'h33);

    write(8'h20, 8'h11);
    cs = 1'b1; wr = 1'b1; rd = 1'b1; addr = 8'h20; din = 8'h22;
    tick;
    chk("rw_read_first", dout, 8'h11);
    cs = 1'b0; wr = 1'b0; rd = 1'b0;
    read(8'h20);
    chk("rw_write_done", dout, 8'h22);

    write(8'h01, 8'hC3);
    read(8'h01);
    chk("idle_pre", dout, 8'hC3);
    for (int i = 0; i < 5; i++) begin
      cs = (i < 3); wr = 1'b0; rd = 1'b0; addr = 8'h02;
      tick;
      chk("idle_hold", dout, 8'hC3);
    end
    cs = 1'b0;

`ifdef SRAM_CLEAR_ON_RESET_EN
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    cs = 1'b1; rd = 1'b1; addr = 8'h01;
    for (int i = 0; i < 100; i++) tick;
    chk("busy_mid_sweep", busy, 1'b1);
    chk("dout_mid_sweep", dout, 8'h00);
    cs = 1'b0; rd = 1'b0;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    wait_clear(n);
    chk("restart_sweep_len", n, 256);
    chk("busy_done", busy, 1'b0);
    read(8'h00);
    chk("clear_00", dout, 8'h00);
    read(8'h80);
    chk("clear_80", dout, 8'h00);
    read(8'hFF);
    chk("clear_ff", dout, 8'h00);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sram_256x8.md
Name: sram_256x8

Overview:
- Single-port synchronous static RAM, 256 words x 8 bits by default.
- Provides chip-select-gated write and read strobes.
- Read data is registered.
- Used as a general-purpose scratch/storage block. A master (CPU, DMA or bench) fills it with write strobes and later reads back random addresses.

Parameters:
- ADDR_W, 8, address width; DEPTH = 2**ADDR_W words.
- DATA_W, 8, word width in bits.

Ports:
- clk  in  1  rising-edge clock; all state changes on this edge.
- rst_n  in  1  synchronous active-low reset.
- cs  in  1  chip select, active high; no access when low.
- wr  in  1  write strobe, active high, qualified by cs.
- rd  in  1  read strobe, active high, qualified by cs.
- addr  in  ADDR_W  word address.
- din  in  DATA_W  write data.
- dout  out  DATA_W  registered read data.

Behaviour:
- Reset (rst_n=0 at a rising clk edge):
  - dout <= 0.
  - Any in-progress access is abandoned; writes presented in the reset cycle are NOT performed.
  - Memory contents are not cleared by reset (undefined/X until written) unless the optional feature is enabled.
- Write: on a rising clk with rst_n=1, cs=1 and wr=1, mem[addr] <= din. Takes effect at that edge.
- Read: on a rising clk with rst_n=1, cs=1 and rd=1, dout <= mem[addr]. Latency is 1 cycle: data is valid after the edge that samples rd.
- wr and rd both high (with cs=1) is a legal simultaneous access:
  - Write is performed.
  - dout returns the OLD contents of mem[addr] (read-first).
- Idle cycle (cs=0, or cs=1 with wr=0 and rd=0): no memory change; dout holds its last value.
- Addressing: full address range 0..DEPTH-1 is valid; no wrap or out-of-range case exists since DEPTH=2**ADDR_W.
- Back-to-back accesses are allowed every cycle, to any addresses, in any order; no handshake or busy signal.
- Port widths are exact; din and addr are used as-is, with no extension or truncation.

Optional Feature:
- Macro: SRAM_CLEAR_ON_RESET_EN.
- With the macro defined:
  - Adds output port busy (1 bit).
  - Leaving reset (first cycle with rst_n=1 after rst_n=0) starts a clear sweep. A counter walks addresses 0..DEPTH-1, writing 0 one word per cycle, so the sweep takes DEPTH cycles.
  - busy=1 throughout the sweep; busy resets to 1 and falls after the write of address DEPTH-1.
  - While busy=1, cs/wr/rd are ignored and dout holds 0.
  - Reassertion of rst_n mid-sweep restarts the sweep from address 0.
  - States: CLEAR, READY.
- Without the macro: no busy port, no counter, and the memory is not initialised.

Decomposition:
- Package sram_pkg holds the default ADDR_W/DATA_W constants and, when the feature is enabled, the state enum {CLEAR, READY}.
- One sub-module, sram_array: the storage array only, with clk, we, waddr, wdata, raddr and registered rdata, implementing read-first behaviour.
- The top level handles cs gating, reset of dout and the optional clear FSM.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with cs=1, wr=1, addr=0x05, din=0xAA -> dout=0x00; a later read of 0x05 shows mem was not written by that stimulus.
- Fill/readback: write mem[k]=k^0x5A for k=0..255 (cs=1, wr=1, rd=0), then read 256 pseudo-random addresses (wr=0, rd=1) -> dout equals k^0x5A one cycle after each read strobe.
- Chip select: with mem[0x10]=0x33, apply cs=0, wr=1, addr=0x10, din=0xFF, then read 0x10 -> dout=0x33. Any cs=0 cycle leaves dout unchanged.
- Simultaneous access: with mem[0x20]=0x11, apply cs=1, wr=1, rd=1, addr=0x20, din=0x22 -> dout=0x11 that cycle; the next read of 0x20 gives dout=0x22.
- Idle hold: read 0x01 (=0xC3), then 5 idle cycles with rd=0 -> dout stays 0xC3.
- SRAM_CLEAR_ON_RESET_EN: after reset, busy=1 for 256 cycles, then 0; reads of 0x00, 0x80 and 0xFF return 0x00. Pulsing rst_n at sweep cycle 100 restarts a full 256-cycle busy period.
